// File: rtl/multi_timer_if.sv
// Request/response bus between the data-memory request port and the multi_timer peripheral.
// The master issues one request per cycle. The slave answers one cycle later.
interface multi_timer_if #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int MEM_COUNT_W = 2,
    parameter int MEM_CODE_W  = 2
);
    logic [ADDR_W-1:0]      i_req_addr;
    logic [WORD_W-1:0]      i_req_wr_data;
    logic                   i_req_wr_en;
    logic [MEM_COUNT_W-1:0] i_req_count;
    logic [WORD_W-1:0]      o_res_rd_data;
    logic [MEM_CODE_W-1:0]  o_res_code;

    modport master (
        output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
        input  o_res_rd_data, o_res_code
    );

    modport slave (
        input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count,
        output o_res_rd_data, o_res_code
    );
endinterface

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer with per-channel compare, one-shot/periodic modes and an aggregated IRQ.
// Optional per-channel 8-bit prescaler is compiled in when TIMER_PRESCALER_EN is defined.
module multi_timer #(
    parameter logic [31:0] ADDR_START = 32'h0,
    parameter int          CHANNELS   = 2
) (
    input  logic         clk,
    input  logic         aresetn,
    multi_timer_if.slave bus,
    output logic         o_irq
);
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int MEM_CODE_W = 2;
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [1:0] MEM_COUNT_WORD = 2'd3;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE          = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK            = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 2'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(CHANNELS * 16);

    logic [ADDR_W-1:0]     w_off;
    logic [CH_W-1:0]       w_ch;
    logic [1:0]            w_reg;
    logic [1:0]            w_byte;
    logic                  w_in_win;
    logic                  w_misaligned;
    logic [MEM_CODE_W-1:0] w_code;
    logic [3:0]            w_lanes;
    logic [WORD_W-1:0]     w_size_mask;
    logic [WORD_W-1:0]     w_wdata;
    logic [WORD_W-1:0]     w_sel_word;
    logic [WORD_W-1:0]     w_rd_data;
    logic                  w_wr_ok;
    logic [CHANNELS-1:0]   w_hit;
    logic [CHANNELS-1:0]   w_wr_ctrl;
    logic [CHANNELS-1:0]   w_wr_count;
    logic [CHANNELS-1:0]   w_wr_cmp;
    logic [CHANNELS-1:0]   w_wr_status;
    logic [CHANNELS-1:0]   w_tick;
    logic [CHANNELS-1:0]   w_at_cmp;

    logic [CHANNELS-1:0]   r_en;
    logic [CHANNELS-1:0]   r_periodic;
    logic [CHANNELS-1:0]   r_irq_en;
    logic [CHANNELS-1:0]   r_match;
    logic [WORD_W-1:0]     r_count [CHANNELS];
    logic [WORD_W-1:0]     r_cmp   [CHANNELS];
    logic [WORD_W-1:0]     r_rd_data;
    logic [MEM_CODE_W-1:0] r_code;
`ifdef TIMER_PRESCALER_EN
    logic [7:0]            r_prescale [CHANNELS];
    logic [7:0]            r_psc_cnt  [CHANNELS];
`endif

    function automatic logic [WORD_W-1:0] merge_lanes(
        input logic [WORD_W-1:0] old_val,
        input logic [WORD_W-1:0] new_val,
        input logic [3:0]        lanes
    );
        logic [WORD_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Addresses below ADDR_START wrap to a huge offset, so one compare covers both window edges.
    always_comb begin
        w_off        = bus.i_req_addr - ADDR_START;
        w_in_win     = (w_off < WIN_BYTES);
        w_ch         = w_off[4 +: CH_W];
        w_reg        = w_off[3:2];
        w_byte       = w_off[1:0];
        w_misaligned = ((bus.i_req_count == MEM_COUNT_WORD) && (w_byte != 2'd0)) ||
                       ((bus.i_req_count == MEM_COUNT_HALF) && w_byte[0]);

        if (bus.i_req_count == MEM_COUNT_NONE) w_code = MEM_CODE_NONE;
        else if (!w_in_win)                    w_code = MEM_CODE_OUT_OF_BOUNDS;
        else if (w_misaligned)                 w_code = MEM_CODE_MISALIGNED;
        else                                   w_code = MEM_CODE_OK;

        w_lanes     = 4'b0000;
        w_size_mask = '0;
        case (bus.i_req_count)
            MEM_COUNT_BYTE: begin
                w_lanes     = 4'b0001 << w_byte;
                w_size_mask = 32'h0000_00FF;
            end
            MEM_COUNT_HALF: begin
                w_lanes     = 4'b0011 << w_byte;
                w_size_mask = 32'h0000_FFFF;
            end
            MEM_COUNT_WORD: begin
                w_lanes     = 4'b1111;
                w_size_mask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase

        w_wdata = bus.i_req_wr_data << {w_byte, 3'b000};
        w_wr_ok = (w_code == MEM_CODE_OK) && bus.i_req_wr_en;
    end

    always_comb begin
        w_hit       = '0;
        w_wr_ctrl   = '0;
        w_wr_count  = '0;
        w_wr_cmp    = '0;
        w_wr_status = '0;
        w_sel_word  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_hit[c]       = w_in_win && (w_ch == CH_W'(c));
            w_wr_ctrl[c]   = w_wr_ok && w_hit[c] && (w_reg == REG_CTRL);
            w_wr_count[c]  = w_wr_ok && w_hit[c] && (w_reg == REG_COUNT);
            w_wr_cmp[c]    = w_wr_ok && w_hit[c] && (w_reg == REG_CMP);
            w_wr_status[c] = w_wr_ok && w_hit[c] && (w_reg == REG_STATUS);
            if (w_hit[c]) begin
                case (w_reg)
`ifdef TIMER_PRESCALER_EN
                    REG_CTRL:  w_sel_word = {16'h0, r_prescale[c], 5'h0,
                                             r_irq_en[c], r_periodic[c], r_en[c]};
`else
                    REG_CTRL:  w_sel_word = {16'h0, 8'h0, 5'h0,
                                             r_irq_en[c], r_periodic[c], r_en[c]};
`endif
                    REG_COUNT: w_sel_word = r_count[c];
                    REG_CMP:   w_sel_word = r_cmp[c];
                    default:   w_sel_word = {31'h0, r_match[c]};
                endcase
            end
        end
        w_rd_data = (w_sel_word >> {w_byte, 3'b000}) & w_size_mask;
    end

    always_comb begin
        w_tick   = '0;
        w_at_cmp = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_at_cmp[c] = (r_count[c] == r_cmp[c]);
`ifdef TIMER_PRESCALER_EN
            w_tick[c]   = r_en[c] && (r_psc_cnt[c] == r_prescale[c]);
`else
            w_tick[c]   = r_en[c];
`endif
        end
    end

    // Write responses carry zero data; only OK reads return register contents.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_data <= '0;
            r_code    <= MEM_CODE_NONE;
        end else begin
            r_code    <= w_code;
            r_rd_data <= ((w_code == MEM_CODE_OK) && !bus.i_req_wr_en) ? w_rd_data : '0;
        end
    end

    // Bus writes are applied after the hardware update so they win any same-cycle conflict,
    // except MATCH where the hardware set has priority over the W1C clear.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_en       <= '0;
            r_periodic <= '0;
            r_irq_en   <= '0;
            r_match    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_count[c]    <= '0;
                r_cmp[c]      <= '0;
`ifdef TIMER_PRESCALER_EN
                r_prescale[c] <= '0;
                r_psc_cnt[c]  <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr_count[c]) begin
                    r_count[c] <= merge_lanes(r_count[c], w_wdata, w_lanes);
                end else if (w_tick[c]) begin
                    if (!w_at_cmp[c])      r_count[c] <= r_count[c] + 1'b1;
                    else if (r_periodic[c]) r_count[c] <= '0;
                end

                if (w_tick[c] && w_at_cmp[c]) begin
                    r_match[c] <= 1'b1;
                end else if (w_wr_status[c] && w_lanes[0] && w_wdata[0]) begin
                    r_match[c] <= 1'b0;
                end

                if (w_wr_ctrl[c] && w_lanes[0]) begin
                    r_en[c]       <= w_wdata[0];
                    r_periodic[c] <= w_wdata[1];
                    r_irq_en[c]   <= w_wdata[2];
                end else if (w_tick[c] && w_at_cmp[c] && !r_periodic[c]) begin
                    r_en[c] <= 1'b0;
                end

                if (w_wr_cmp[c]) begin
                    r_cmp[c] <= merge_lanes(r_cmp[c], w_wdata, w_lanes);
                end

`ifdef TIMER_PRESCALER_EN
                if (w_wr_ctrl[c] && w_lanes[1]) begin
                    r_prescale[c] <= w_wdata[15:8];
                end
                if (r_en[c]) begin
                    r_psc_cnt[c] <= (r_psc_cnt[c] == r_prescale[c]) ? 8'h00 : r_psc_cnt[c] + 8'h01;
                end
`endif
            end
        end
    end

    assign bus.o_res_rd_data = r_rd_data;
    assign bus.o_res_code    = r_code;
    assign o_irq             = |(r_match & r_irq_en);
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: reset, periodic/one-shot counting, W1C, request checks, byte lanes.
// Expected values are hand-computed; the prescaler case adapts to TIMER_PRESCALER_EN.
module tb_multi_timer;
    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_BYTE = 2'd1;
    localparam logic [1:0] C_HALF = 2'd2;
    localparam logic [1:0] C_WORD = 2'd3;
    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_OK   = 2'd1;
    localparam logic [1:0] R_MIS  = 2'd2;
    localparam logic [1:0] R_OOB  = 2'd3;
    localparam logic [31:0] BASE  = 32'h0000_0100;
`ifdef TIMER_PRESCALER_EN
    localparam int          EXP_LAT  = 12;
    localparam logic [31:0] EXP_CTRL = 32'h0000_0304;
`else
    localparam int          EXP_LAT  = 3;
    localparam logic [31:0] EXP_CTRL = 32'h0000_0004;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        o_irq;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_code;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_wait;

    multi_timer_if bus ();

    multi_timer #(.ADDR_START(BASE), .CHANNELS(2)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus),
        .o_irq   (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [1:0] cnt);
        @(negedge clk);
        bus.i_req_addr    = a;
        bus.i_req_wr_data = d;
        bus.i_req_wr_en   = w;
        bus.i_req_count   = cnt;
        @(posedge clk);
        #1;
        rsp_data = bus.o_res_rd_data;
        rsp_code = bus.o_res_code;
        bus.i_req_count = C_NONE;
        bus.i_req_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_addr    = '0;
        bus.i_req_wr_data = '0;
        bus.i_req_wr_en   = 1'b0;
        bus.i_req_count   = C_NONE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", 32'(bus.o_res_code), 32'(R_NONE));
        check("rst_data", bus.o_res_rd_data, 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;

        access(BASE + 4, 0, 1'b0, C_WORD);
        check("rst_rd_data", rsp_data, 32'h0);
        check("rst_rd_code", 32'(rsp_code), 32'(R_OK));
        check("rst_rd_irq", 32'(o_irq), 32'h0);

        // ch0 periodic, CMP=5
        access(BASE + 8, 32'd5, 1'b1, C_WORD);
        access(BASE + 0, 32'h7, 1'b1, C_WORD);
        for (int i = 0; i < 6; i++) begin
            access(BASE + 4, 0, 1'b0, C_WORD);
            check("per1_count", rsp_data, 32'(i));
            check("per1_irq", 32'(o_irq), 32'(i == 5));
        end
        for (int i = 0; i < 6; i++) begin
            access(BASE + 4, 0, 1'b0, C_WORD);
            check("per2_count", rsp_data, 32'(i));
        end
        access(BASE + 12, 32'h1, 1'b1, C_WORD);
        check("w1c_irq", 32'(o_irq), 32'h0);
        access(BASE + 12, 0, 1'b0, C_WORD);
        check("w1c_status", rsp_data, 32'h0);
        access(BASE + 0, 32'h0, 1'b1, C_WORD);

        // ch1 one-shot, CMP=3, W1C lands on the match edge
        access(BASE + 24, 32'd3, 1'b1, C_WORD);
        access(BASE + 16, 32'h1, 1'b1, C_WORD);
        for (int i = 0; i < 3; i++) begin
            access(BASE + 20, 0, 1'b0, C_WORD);
            check("os_count", rsp_data, 32'(i));
        end
        access(BASE + 28, 32'h1, 1'b1, C_WORD);
        access(BASE + 28, 0, 1'b0, C_WORD);
        check("os_match_wins", rsp_data, 32'h1);
        access(BASE + 20, 0, 1'b0, C_WORD);
        check("os_hold", rsp_data, 32'd3);
        access(BASE + 16, 0, 1'b0, C_WORD);
        check("os_en_clr", rsp_data, 32'h0);
        check("os_irq", 32'(o_irq), 32'h0);

        // re-enable keeps COUNT
        access(BASE + 24, 32'd10, 1'b1, C_WORD);
        access(BASE + 16, 32'h1, 1'b1, C_WORD);
        access(BASE + 20, 0, 1'b0, C_WORD);
        check("reen_count0", rsp_data, 32'd3);
        access(BASE + 20, 0, 1'b0, C_WORD);
        check("reen_count1", rsp_data, 32'd4);

        // request checks
        access(BASE + 2, 0, 1'b0, C_WORD);
        check("mis_code", 32'(rsp_code), 32'(R_MIS));
        check("mis_data", rsp_data, 32'h0);
        access(BASE + 32, 0, 1'b0, C_WORD);
        check("oob_code", 32'(rsp_code), 32'(R_OOB));
        check("oob_data", rsp_data, 32'h0);
        access(BASE - 4, 0, 1'b0, C_WORD);
        check("oob_low_code", 32'(rsp_code), 32'(R_OOB));
        access(BASE + 9, 0, 1'b0, C_HALF);
        check("mis_half_code", 32'(rsp_code), 32'(R_MIS));
        access(BASE + 8, 0, 1'b0, C_NONE);
        check("none_code", 32'(rsp_code), 32'(R_NONE));
        access(BASE + 10, 32'hDEAD, 1'b1, C_WORD);
        check("mis_wr_code", 32'(rsp_code), 32'(R_MIS));
        access(BASE + 8, 0, 1'b0, C_WORD);
        check("mis_wr_noeffect", rsp_data, 32'd5);

        // byte lanes on ch0 CMP
        access(BASE + 8, 32'h1122_3344, 1'b1, C_WORD);
        access(BASE + 9, 32'hAB, 1'b1, C_BYTE);
        access(BASE + 8, 0, 1'b0, C_WORD);
        check("lane_word", rsp_data, 32'h1122_AB44);
        access(BASE + 8, 0, 1'b0, C_HALF);
        check("lane_half_lo", rsp_data, 32'h0000_AB44);
        access(BASE + 10, 0, 1'b0, C_HALF);
        check("lane_half_hi", rsp_data, 32'h0000_1122);
        access(BASE + 11, 0, 1'b0, C_BYTE);
        check("lane_byte", rsp_data, 32'h0000_0011);

        // prescaler: ch0 one-shot, CMP=2, PRESCALE=3, IRQ enabled
        access(BASE + 4, 32'h0, 1'b1, C_WORD);
        access(BASE + 8, 32'd2, 1'b1, C_WORD);
        access(BASE + 12, 32'h1, 1'b1, C_WORD);
        access(BASE + 0, 32'h0305, 1'b1, C_WORD);
        n_wait = 0;
        while ((n_wait < 40) && (o_irq !== 1'b1)) begin
            @(posedge clk);
            #1;
            n_wait++;
        end
        check("psc_latency", 32'(n_wait), 32'(EXP_LAT));
        access(BASE + 0, 0, 1'b0, C_WORD);
        check("psc_ctrl", rsp_data, EXP_CTRL);
        access(BASE + 4, 0, 1'b0, C_WORD);
        check("psc_count", rsp_data, 32'd2);
        access(BASE + 12, 0, 1'b0, C_WORD);
        check("psc_match", rsp_data, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
# multi_timer

Memory-mapped, parametrised multi-channel timer peripheral on the data-memory request bus, next to the other memory peripherals. Each of `CHANNELS` independent channels has a free-running or compare-terminated counter with one-shot/periodic modes, a sticky match flag and interrupt enable. Requests are checked for range, alignment and size, then answered one cycle later with read data and a response code. A single aggregated interrupt line goes to the core.

## Interface
- `ADDR_START`, 0: byte base address of the register window.
- `CHANNELS`, 2: number of timer channels, 1..8.
- `clk` in 1: clock.
- `aresetn` in 1: reset; asynchronous, active-low.
- `i_req_addr` in `ADDR_W`: request byte address.
- `i_req_wr_data` in `WORD_W`: write data, right-aligned.
- `i_req_wr_en` in 1: 1 = write, 0 = read.
- `i_req_count` in `MEM_COUNT_W`: access size: `MEM_COUNT_NONE`, byte, `MEM_COUNT_HALF`, `MEM_COUNT_WORD`.
- `o_res_rd_data` out `WORD_W`: registered read data.
- `o_res_code` out `MEM_CODE_W`: registered response code.
- `o_irq` out 1: OR over channels of (MATCH & IRQ_EN); driven from registers, no combinational path from inputs.

## Operation
- Window is `CHANNELS*16` bytes from `ADDR_START`. Channel n starts at `ADDR_START+16n`.
- Channel registers:
  - +0 CTRL: [0] EN, [1] PERIODIC, [2] IRQ_EN, [15:8] PRESCALE.
  - +4 COUNT.
  - +8 CMP.
  - +12 STATUS: [0] MATCH.
  - Reserved bits read 0 and ignore writes.
- Request checks, in priority order:
  - `MEM_COUNT_NONE` → `MEM_CODE_NONE`, no effect.
  - Address outside window → `MEM_CODE_OUT_OF_BOUNDS`.
  - Word access with offset≠0, or half access with offset[0]=1 → `MEM_CODE_MISALIGNED`.
  - Otherwise → `MEM_CODE_OK`.
  - Only OK requests modify state. Non-OK responses return rd_data 0.
- Reads: containing word shifted right by 8×offset, masked to access size, zero-extended.
- Writes: little-endian byte lanes selected by offset and size; untouched lanes keep their value. Half and byte writes are allowed on every register.
- STATUS.MATCH is write-1-to-clear; writing 0 has no effect.
- Counting, per channel, on each tick while EN=1:
  - COUNT==CMP: set MATCH. If PERIODIC, COUNT←0. If one-shot, clear EN and hold COUNT.
  - Otherwise COUNT←COUNT+1, wrapping from 2^`WORD_W`−1 to 0. Wrap alone does not set MATCH.
- Simultaneous events:
  - Bus write to COUNT beats increment or reload in the same cycle.
  - Hardware MATCH set beats a W1C clear in the same cycle.
  - Bus write to CTRL.EN beats the one-shot auto-clear.
- Writing CTRL with EN 0→1 does not reset COUNT or the prescaler.

## Timing
- Reset (async assert, sync-to-clk deassert use): all CTRL/COUNT/CMP/STATUS 0, prescaler counters 0, `o_res_rd_data`=0, `o_res_code`=`MEM_CODE_NONE`, `o_irq`=0.
- Response latency is 1 cycle: request sampled at edge k, response valid after edge k; a new request may be issued every cycle.
- A read in the same cycle as a counter update returns the pre-update value.
- MATCH sets on the edge that detects COUNT==CMP. `o_irq` rises in the same cycle MATCH becomes 1.
- Reset asserted mid-operation immediately clears all state; no pending response survives.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - Each channel has an 8-bit prescaler counter. A tick occurs when prescaler==PRESCALE, then the prescaler resets to 0, so PRESCALE=p gives one tick per p+1 cycles.
  - The prescaler runs only while EN=1.
- `TIMER_PRESCALER_EN` undefined:
  - No prescaler logic; a tick occurs every cycle while EN=1.
  - CTRL[15:8] reads 0 and ignores writes.

## Test plan
- Reset, then word read at `ADDR_START+4` → rd_data 0, code `MEM_CODE_OK`, `o_irq`=0.
- Ch0 CMP=5, CTRL=0x7 (EN, periodic, IRQ) → COUNT sequence 0..5, MATCH and `o_irq` after the 6th tick, COUNT returns to 0, pattern repeats. W1C STATUS=1 drops `o_irq` next cycle.
- Ch1 one-shot, CMP=3, EN → COUNT holds 3, EN reads 0, MATCH=1. A W1C on the match cycle leaves MATCH=1.
- Word read at `ADDR_START+2` → `MEM_CODE_MISALIGNED`. Read at `ADDR_START+CHANNELS*16` → `MEM_CODE_OUT_OF_BOUNDS`. Neither changes state.
- Byte write 0xAB to `ADDR_START+9` with CMP=0x11223344 → CMP=0x1122AB44. Half read at +8 → 0xAB44.
- With `TIMER_PRESCALER_EN`, PRESCALE=3, CMP=2 → MATCH after 12 cycles. Without the macro → MATCH after 3 cycles, and CTRL[15:8] reads 0.
